// File: rtl/pid_multi_axis.sv
// pid_multi_axis
//   Time-multiplexed rate PID controller for NUM_CH rotation axes sharing a
//   single signed multiplier. Each run walks every channel through
//   ERR -> PTERM -> ITERM -> DTERM -> SUM, then publishes all outputs at once.
//
// Ports
//   us_clk          system clock
//   resetn          asynchronous active-low reset
//   start_flag      start a run (honoured only while idle)
//   clear_integral  sampled with start_flag; clears integrator/derivative history
//   target_rotation packed signed targets, channel 0 in the LSBs
//   actual_rotation packed signed IMU rates
//   k_p, k_i, k_d   packed signed per-channel gains
//   rate_out        packed clamped outputs
//   saturated       per-channel clamp flag for the current rate_out
//   pid_active      high while channels are being computed
//   pid_complete    one-cycle pulse while rate_out holds freshly published data
module pid_multi_axis #(
  parameter int     NUM_CH     = 3,
  parameter int     IN_WIDTH   = 16,
  parameter int     GAIN_WIDTH = 16,
  parameter int     ACC_WIDTH  = 24,
  parameter int     OUT_WIDTH  = 16,
  parameter int     K_SHIFT    = 4,
  parameter int     IMU_SCALAR = 1,
  parameter longint INT_MIN    = -1048576,
  parameter longint INT_MAX    = 1048575,
  parameter longint OUT_MIN    = -(longint'(1) <<< (OUT_WIDTH - 1)),
  parameter longint OUT_MAX    = (longint'(1) <<< (OUT_WIDTH - 1)) - 1
) (
  input  logic                           us_clk,
  input  logic                           resetn,
  input  logic                           start_flag,
  input  logic                           clear_integral,
  input  logic [NUM_CH*IN_WIDTH-1:0]     target_rotation,
  input  logic [NUM_CH*IN_WIDTH-1:0]     actual_rotation,
  input  logic [NUM_CH*GAIN_WIDTH-1:0]   k_p,
  input  logic [NUM_CH*GAIN_WIDTH-1:0]   k_i,
  input  logic [NUM_CH*GAIN_WIDTH-1:0]   k_d,
  output logic [NUM_CH*OUT_WIDTH-1:0]    rate_out,
  output logic [NUM_CH-1:0]              saturated,
  output logic                           pid_active,
  output logic                           pid_complete
);

  localparam int EW  = IN_WIDTH + 1;                 // error width
  localparam int DW  = IN_WIDTH + 2;                 // error-difference width
  localparam int OPW = (ACC_WIDTH > DW) ? ACC_WIDTH : DW;
  localparam int PW  = GAIN_WIDTH + OPW;             // product width
  localparam int SW  = PW + 2;                       // P+I+D sum width
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic signed [ACC_WIDTH:0] INT_MIN_V = (ACC_WIDTH + 1)'(INT_MIN);
  localparam logic signed [ACC_WIDTH:0] INT_MAX_V = (ACC_WIDTH + 1)'(INT_MAX);
  localparam logic signed [SW-1:0]      OUT_MIN_V = SW'(OUT_MIN);
  localparam logic signed [SW-1:0]      OUT_MAX_V = SW'(OUT_MAX);
  localparam logic [CW-1:0]             LAST_CH   = CW'(NUM_CH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ERR  = 3'd1;
  localparam logic [2:0] S_P    = 3'd2;
  localparam logic [2:0] S_I    = 3'd3;
  localparam logic [2:0] S_D    = 3'd4;
  localparam logic [2:0] S_SUM  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  // Unpacked views of the packed input buses
  logic signed [IN_WIDTH-1:0]   tgt_in [NUM_CH];
  logic signed [IN_WIDTH-1:0]   act_in [NUM_CH];
  logic signed [GAIN_WIDTH-1:0] kp_in  [NUM_CH];
  logic signed [GAIN_WIDTH-1:0] ki_in  [NUM_CH];
  logic signed [GAIN_WIDTH-1:0] kd_in  [NUM_CH];

  // State
  logic [2:0]                   state_q;
  logic [CW-1:0]                ch_q;
  logic                         clr_q;
  logic signed [IN_WIDTH-1:0]   tgt_q [NUM_CH];
  logic signed [IN_WIDTH-1:0]   act_q [NUM_CH];
  logic signed [GAIN_WIDTH-1:0] kp_q  [NUM_CH];
  logic signed [GAIN_WIDTH-1:0] ki_q  [NUM_CH];
  logic signed [GAIN_WIDTH-1:0] kd_q  [NUM_CH];
  logic signed [ACC_WIDTH-1:0]  acc_q [NUM_CH];
  logic signed [EW-1:0]         prev_err_q [NUM_CH];
  logic [NUM_CH-1:0]            first_q;
  logic [NUM_CH-1:0]            sat_hi_q;
  logic [NUM_CH-1:0]            sat_lo_q;
  logic signed [OUT_WIDTH-1:0]  stage_q [NUM_CH];
  logic signed [OUT_WIDTH-1:0]  rate_q  [NUM_CH];
  logic [NUM_CH-1:0]            saturated_q;
  logic                         complete_q;
  logic signed [EW-1:0]         e_q;
  logic signed [PW-1:0]         p_q, i_q, d_q;

  // Combinational next values
  logic signed [IN_WIDTH-1:0]   act_sh;
  logic signed [EW-1:0]         e_d;
  logic signed [ACC_WIDTH-1:0]  acc_base, acc_clamp, acc_d;
  logic signed [ACC_WIDTH:0]    acc_sum;
  logic                         inhibit;
  logic signed [DW-1:0]         diff;
  logic signed [GAIN_WIDTH-1:0] mul_a;
  logic signed [OPW-1:0]        mul_b;
  logic signed [PW-1:0]         prod, prod_sh;
  logic signed [SW-1:0]         sum_d;
  logic                         hi_d, lo_d;
  logic signed [OUT_WIDTH-1:0]  out_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign tgt_in[gi] = target_rotation[gi*IN_WIDTH +: IN_WIDTH];
      assign act_in[gi] = actual_rotation[gi*IN_WIDTH +: IN_WIDTH];
      assign kp_in[gi]  = k_p[gi*GAIN_WIDTH +: GAIN_WIDTH];
      assign ki_in[gi]  = k_i[gi*GAIN_WIDTH +: GAIN_WIDTH];
      assign kd_in[gi]  = k_d[gi*GAIN_WIDTH +: GAIN_WIDTH];
      assign rate_out[gi*OUT_WIDTH +: OUT_WIDTH] = rate_q[gi];
    end
  endgenerate

  always_comb begin
    // Error and integrator update (used in ERR)
    act_sh    = act_q[ch_q] >>> IMU_SCALAR;
    e_d       = EW'(tgt_q[ch_q]) - EW'(act_sh);
    acc_base  = clr_q ? '0 : acc_q[ch_q];
    acc_sum   = (ACC_WIDTH + 1)'(acc_base) + (ACC_WIDTH + 1)'(e_d);
    if (acc_sum > INT_MAX_V)      acc_clamp = ACC_WIDTH'(INT_MAX_V);
    else if (acc_sum < INT_MIN_V) acc_clamp = ACC_WIDTH'(INT_MIN_V);
    else                          acc_clamp = ACC_WIDTH'(acc_sum);
    // Conditional integration: do not push further into a saturated output
    inhibit   = (sat_hi_q[ch_q] && !e_d[EW-1] && (e_d != '0)) ||
                (sat_lo_q[ch_q] && e_d[EW-1]);
    acc_d     = inhibit ? acc_base : acc_clamp;

    // Shared multiplier: operand pair chosen by the term being formed
    diff  = DW'(e_q) - DW'(prev_err_q[ch_q]);
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_P: begin mul_a = kp_q[ch_q]; mul_b = OPW'(e_q);         end
      S_I: begin mul_a = ki_q[ch_q]; mul_b = OPW'(acc_q[ch_q]); end
      S_D: begin mul_a = kd_q[ch_q]; mul_b = OPW'(diff);        end
      default: ;
    endcase
    prod    = PW'(mul_a) * PW'(mul_b);
    prod_sh = prod >>> K_SHIFT;

    // Output sum and clamp (used in SUM)
    sum_d = SW'(p_q) + SW'(i_q) + SW'(d_q);
    hi_d  = sum_d > OUT_MAX_V;
    lo_d  = sum_d < OUT_MIN_V;
    if (hi_d)      out_d = OUT_WIDTH'(OUT_MAX_V);
    else if (lo_d) out_d = OUT_WIDTH'(OUT_MIN_V);
    else           out_d = OUT_WIDTH'(sum_d);
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      clr_q       <= 1'b0;
      first_q     <= '1;
      sat_hi_q    <= '0;
      sat_lo_q    <= '0;
      saturated_q <= '0;
      complete_q  <= 1'b0;
      e_q         <= '0;
      p_q         <= '0;
      i_q         <= '0;
      d_q         <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        tgt_q[k]      <= '0;
        act_q[k]      <= '0;
        kp_q[k]       <= '0;
        ki_q[k]       <= '0;
        kd_q[k]       <= '0;
        acc_q[k]      <= '0;
        prev_err_q[k] <= '0;
        stage_q[k]    <= '0;
        rate_q[k]     <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_flag) begin
            for (int k = 0; k < NUM_CH; k++) begin
              tgt_q[k] <= tgt_in[k];
              act_q[k] <= act_in[k];
              kp_q[k]  <= kp_in[k];
              ki_q[k]  <= ki_in[k];
              kd_q[k]  <= kd_in[k];
            end
            clr_q   <= clear_integral;
            ch_q    <= '0;
            state_q <= S_ERR;
          end
        end
        S_ERR: begin
          e_q         <= e_d;
          acc_q[ch_q] <= acc_d;
          if (clr_q) begin
            prev_err_q[ch_q] <= '0;
            first_q[ch_q]    <= 1'b1;
          end
          state_q <= S_P;
        end
        S_P: begin
          p_q     <= prod_sh;
          state_q <= S_I;
        end
        S_I: begin
          i_q     <= prod_sh;
          state_q <= S_D;
        end
        S_D: begin
          d_q              <= first_q[ch_q] ? '0 : prod_sh;
          prev_err_q[ch_q] <= e_q;
          first_q[ch_q]    <= 1'b0;
          state_q          <= S_SUM;
        end
        S_SUM: begin
          stage_q[ch_q]  <= out_d;
          sat_hi_q[ch_q] <= hi_d;
          sat_lo_q[ch_q] <= lo_d;
          if (ch_q == LAST_CH) begin
            // Publish every channel on the edge entering DONE; the last
            // channel bypasses its staging slot so all values land together.
            for (int k = 0; k < NUM_CH; k++) begin
              if (CW'(k) == ch_q) begin
                rate_q[k]      <= out_d;
                saturated_q[k] <= hi_d | lo_d;
              end else begin
                rate_q[k]      <= stage_q[k];
                saturated_q[k] <= sat_hi_q[k] | sat_lo_q[k];
              end
            end
            complete_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= S_ERR;
          end
        end
        S_DONE: begin
          complete_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign saturated    = saturated_q;
  assign pid_complete = complete_q;
  assign pid_active   = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_pid_multi_axis.sv
// Directed testbench for pid_multi_axis. Two instances run side by side on the
// same stimulus: dut_a with default clamps, dut_b with OUT_MAX=1000, OUT_MIN=-50.
module tb_pid_multi_axis;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_flag;
  logic        clear_integral;
  logic [47:0] target, actual, kp, ki, kd;
  logic [47:0] rate_a, rate_b;
  logic [2:0]  sat_a, sat_b;
  logic        act_a, act_b, cmp_a, cmp_b;

  int checks   = 0;
  int failures = 0;
  int done_cyc, act_cnt, cmp_cnt;
  int run_no = 0;

  always #5 clk = ~clk;

  pid_multi_axis dut_a (
    .us_clk(clk), .resetn(resetn), .start_flag(start_flag),
    .clear_integral(clear_integral),
    .target_rotation(target), .actual_rotation(actual),
    .k_p(kp), .k_i(ki), .k_d(kd),
    .rate_out(rate_a), .saturated(sat_a),
    .pid_active(act_a), .pid_complete(cmp_a)
  );

  pid_multi_axis #(.OUT_MAX(1000), .OUT_MIN(-50)) dut_b (
    .us_clk(clk), .resetn(resetn), .start_flag(start_flag),
    .clear_integral(clear_integral),
    .target_rotation(target), .actual_rotation(actual),
    .k_p(kp), .k_i(ki), .k_d(kd),
    .rate_out(rate_b), .saturated(sat_b),
    .pid_active(act_b), .pid_complete(cmp_b)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ch_of(input logic [47:0] v, input int c);
    logic signed [15:0] s;
    s = v[c*16 +: 16];
    return int'(s);
  endfunction

  task automatic set_ch(input int c, input int t, input int a,
                        input int p, input int i, input int d);
    target[c*16 +: 16] = 16'(t);
    actual[c*16 +: 16] = 16'(a);
    kp[c*16 +: 16]     = 16'(p);
    ki[c*16 +: 16]     = 16'(i);
    kd[c*16 +: 16]     = 16'(d);
  endtask

  task automatic zero_inputs();
    target = '0; actual = '0; kp = '0; ki = '0; kd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // One run: start sampled at edge 0, observe cycles 1..30 on the falling edge.
  // inject_at > 0 raises start_flag again during that cycle (must be ignored).
  task automatic run_pid(input logic clr, input int inject_at);
    start_flag     = 1'b1;
    clear_integral = clr;
    @(posedge clk);
    #1;
    start_flag     = 1'b0;
    clear_integral = 1'b0;
    done_cyc = -1; act_cnt = 0; cmp_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start_flag = (c == inject_at);
      if (act_a) act_cnt++;
      if (cmp_a) begin
        cmp_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    start_flag = 1'b0;
    run_no++;
    $display("run %0d: a=%0d/%0d/%0d sat_a=%b b=%0d/%0d/%0d sat_b=%b done=%0d",
             run_no, ch_of(rate_a, 0), ch_of(rate_a, 1), ch_of(rate_a, 2), sat_a,
             ch_of(rate_b, 0), ch_of(rate_b, 1), ch_of(rate_b, 2), sat_b, done_cyc);
    check_val("single_complete", cmp_cnt, 1);
  endtask

  initial begin
    resetn = 1'b0; start_flag = 1'b0; clear_integral = 1'b0;
    zero_inputs();
    #1;
    check_val("rst_rate_a", int'(rate_a), 0);
    check_val("rst_sat_a", int'(sat_a), 0);
    check_val("rst_active_a", int'(act_a), 0);
    check_val("rst_complete_a", int'(cmp_a), 0);
    check_val("rst_rate_b", int'(rate_b[31:0]), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Proportional only: e = 100 - (40>>>1) = 80 -> 80; timing of the handshake
    set_ch(0, 100, 40, 16, 0, 0);
    run_pid(1'b0, 0);
    check_val("p_ch0", ch_of(rate_a, 0), 80);
    check_val("p_ch1", ch_of(rate_a, 1), 0);
    check_val("p_sat", int'(sat_a), 0);
    check_val("p_done_cycle", done_cyc, 16);
    check_val("p_active_cycles", act_cnt, 15);

    // Integrator accumulates 10 per run; clear_integral restarts it
    do_reset();
    zero_inputs();
    set_ch(0, 10, 0, 0, 16, 0);
    run_pid(1'b0, 0); check_val("i_run1", ch_of(rate_a, 0), 10);
    run_pid(1'b0, 0); check_val("i_run2", ch_of(rate_a, 0), 20);
    run_pid(1'b0, 0); check_val("i_run3", ch_of(rate_a, 0), 30);
    run_pid(1'b1, 0); check_val("i_clear", ch_of(rate_a, 0), 10);

    // Anti-windup in dut_b (OUT_MAX=1000); dut_a integrates unclamped
    do_reset();
    zero_inputs();
    set_ch(0, 600, 0, 0, 16, 0);
    run_pid(1'b0, 0);
    check_val("aw_b_run1", ch_of(rate_b, 0), 600);
    check_val("aw_b_sat1", int'(sat_b), 0);
    run_pid(1'b0, 0);
    check_val("aw_b_run2", ch_of(rate_b, 0), 1000);
    check_val("aw_b_sat2", int'(sat_b), 1);
    check_val("aw_a_run2", ch_of(rate_a, 0), 1200);
    run_pid(1'b0, 0);
    check_val("aw_b_run3", ch_of(rate_b, 0), 1000);
    check_val("aw_a_run3", ch_of(rate_a, 0), 1800);
    set_ch(0, -300, 0, 0, 16, 0);
    run_pid(1'b0, 0);
    check_val("aw_b_run4", ch_of(rate_b, 0), 900);
    check_val("aw_b_sat4", int'(sat_b), 0);
    check_val("aw_a_run4", ch_of(rate_a, 0), 1500);

    // Derivative: first sample suppressed, then 16*(e - prev)/16
    do_reset();
    zero_inputs();
    set_ch(0, 50, 0, 0, 0, 16);
    run_pid(1'b0, 0); check_val("d_run1", ch_of(rate_a, 0), 0);
    set_ch(0, 80, 0, 0, 0, 16);
    run_pid(1'b0, 0); check_val("d_run2", ch_of(rate_a, 0), 30);
    set_ch(0, 20, 0, 0, 0, 16);
    run_pid(1'b0, 0); check_val("d_run3", ch_of(rate_a, 0), -60);

    // All channels, output range extremes
    do_reset();
    zero_inputs();
    set_ch(0, -100, 0, 16, 0, 0);
    set_ch(1, 0, 0, 16, 0, 0);
    set_ch(2, 32767, 0, 16, 0, 0);
    run_pid(1'b0, 0);
    check_val("mc_a_ch0", ch_of(rate_a, 0), -100);
    check_val("mc_a_ch1", ch_of(rate_a, 1), 0);
    check_val("mc_a_ch2", ch_of(rate_a, 2), 32767);
    check_val("mc_a_sat", int'(sat_a), 0);
    check_val("mc_b_ch0", ch_of(rate_b, 0), -50);
    check_val("mc_b_ch2", ch_of(rate_b, 2), 1000);
    check_val("mc_b_sat", int'(sat_b), 5);

    // Start pulse while busy is ignored (single complete checked in run_pid)
    set_ch(0, 100, 40, 16, 0, 0);
    run_pid(1'b0, 5);
    check_val("busy_start_ch0", ch_of(rate_a, 0), 80);
    check_val("busy_start_done", done_cyc, 16);

    // Reset mid-run aborts to reset values
    start_flag = 1'b1;
    @(posedge clk);
    #1;
    start_flag = 1'b0;
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_val("abort_rate_a", int'(rate_a), 0);
    check_val("abort_sat_b", int'(sat_b), 0);
    check_val("abort_active", int'(act_a), 0);
    check_val("abort_complete", int'(cmp_a), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check_val("abort_idle", int'(act_a), 0);

    // Fresh run after reset: P=50, D suppressed on first sample
    set_ch(0, 50, 0, 16, 0, 16);
    run_pid(1'b0, 0);
    check_val("post_rst_ch0", ch_of(rate_a, 0), 50);
    check_val("post_rst_done", done_cyc, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pid_multi_axis.md
# pid_multi_axis

Time-multiplexed, parametrised rate PID controller serving NUM_CH rotation axes (default roll/pitch/yaw) through one shared signed multiplier. Adds per-channel runtime gains, a true accumulating integrator with clamp and conditional-integration anti-windup, first-sample derivative suppression, and atomic update of all channel outputs. It sits between the IMU/angle stage and the motor mixer; a start/complete handshake sequences it.

## Interface
- NUM_CH, 3, number of axes processed per run
- IN_WIDTH, 16, signed width of target/actual samples
- GAIN_WIDTH, 16, signed width of each gain
- ACC_WIDTH, 24, signed width of integral accumulator
- OUT_WIDTH, 16, signed width of each rate output
- K_SHIFT, 4, arithmetic right shift applied to every product
- IMU_SCALAR, 1, arithmetic right shift applied to actual_rotation
- INT_MIN / INT_MAX, -2^20 / 2^20-1, accumulator clamp limits
- OUT_MIN / OUT_MAX, -2^(OUT_WIDTH-1) / 2^(OUT_WIDTH-1)-1, output clamp limits
- us_clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start_flag  in  1  start a run; honoured only in IDLE
- clear_integral  in  1  sampled with start_flag; zeroes integral/derivative history for that run
- target_rotation  in  NUM_CH*IN_WIDTH  packed signed targets, channel 0 in LSBs
- actual_rotation  in  NUM_CH*IN_WIDTH  packed signed IMU rates
- k_p, k_i, k_d  in  NUM_CH*GAIN_WIDTH each  packed signed gains
- rate_out  out  NUM_CH*OUT_WIDTH  packed clamped outputs
- saturated  out  NUM_CH  per-channel clamp flag for current rate_out
- pid_active  out  1  high while computing
- pid_complete  out  1  one-cycle pulse when rate_out updates

## Operation
- Reset: rate_out=0, saturated=0, pid_active=0, pid_complete=0, accumulators=0, prev_err=0, sat direction=none, first-sample flags set, state IDLE.
- States: IDLE -> ERR -> PTERM -> ITERM -> DTERM -> SUM, repeated for ch=0..NUM_CH-1, then DONE -> IDLE.
- IDLE: on start_flag=1, latch all inputs and clear_integral, ch=0, go to ERR. Otherwise hold.
- ERR: e = target - (actual >>> IMU_SCALAR), width IN_WIDTH+1. If latched clear_integral: acc=0, prev_err=0, first flag set. Then integrate: acc_new = clamp(acc+e, INT_MIN, INT_MAX), unless the channel's previous output was saturated high and e>0, or saturated low and e<0. In those cases acc holds.
- PTERM: P = (k_p*e) >>> K_SHIFT.
- ITERM: I = (k_i*acc) >>> K_SHIFT, using the post-update acc.
- DTERM: D = (k_d*(e - prev_err)) >>> K_SHIFT. D=0 if the first flag is set. Then prev_err=e and clear the first flag.
- SUM: s = P+I+D at full width (GAIN_WIDTH+ACC_WIDTH+2). Clamp to OUT_MIN/OUT_MAX into a staging register. Record the saturation direction. Advance ch, or go to DONE after the last channel.
- DONE: copy all staging values to rate_out and saturated simultaneously. Pulse pid_complete. Go to IDLE.
- Only one multiplier exists. Exactly one product is formed in each of PTERM/ITERM/DTERM.
- All arithmetic is signed. Shifts are arithmetic (round toward -inf).

## Timing
- start_flag sampled at edge 0. The ERR state of ch0 occupies cycle 1.
- DONE occupies cycle 5*NUM_CH+1; with the default NUM_CH this is 16 cycles after start.
- rate_out/saturated change at the edge entering DONE. pid_complete is high for that one cycle only.
- pid_active is high in ERR..SUM and low in IDLE and DONE.
- Earliest next start is sampled in the cycle after DONE. start_flag while busy or in DONE is ignored; no queuing.
- Inputs may change freely after edge 0; only latched copies are used.
- Reset asserted mid-run aborts immediately to reset values. rate_out reverts to 0; no partial update is ever visible.

## Test plan
- Config NUM_CH=3, IMU_SCALAR=1, K_SHIFT=4. ch0 k_p=16, k_i=k_d=0, target=100, actual=40 -> rate_out[ch0]=80, saturated=0, pid_complete exactly 16 cycles after start, pid_active high for 15 cycles.
- k_i=16, others 0, e=10 each run, three runs -> ch0 outputs 10, 20, 30. A fourth run with clear_integral=1 -> 10.
- OUT_MAX=1000, k_i=16, e=600 per run -> outputs 600, 1000 (sat=1, acc=1200), 1000 (acc held at 1200). Next run e=-300 -> 900, sat=0.
- k_d=16, others 0: run1 e=50 -> 0 (first sample suppressed); run2 e=80 -> 30; run3 e=20 -> -60.
- k_p=16 on all channels, targets -100/0/32767, actual 0 -> rate_out -100/0/32767. OUT_MIN=-50 -> ch0=-50, saturated[0]=1.
- Pulse start at cycle 5 of a run -> ignored, single pid_complete. Assert resetn=0 at cycle 8 -> all outputs 0 and IDLE. A fresh start after release completes normally with first-sample D suppressed.
